// File: rtl/shared_register_load_arbiter.sv
// Round-robin arbiter that shares one N-bit loadable register between K requesters.
// IDLE picks a winner starting at the priority pointer, GRANT pulses gnt for one
// cycle and loads the winner's data slice on the closing edge.
// Optional build macro: SHARED_REG_OWNER_EN adds an 'owner' output that holds the
// index of the requester whose data currently sits in Q.
module shared_register_load_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned K   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [K-1:0]   req,
  input  logic [K*N-1:0] data,
  input  logic           hold,
  output logic [K-1:0]   gnt,
  output logic [N-1:0]   Q,
  output logic           q_valid,
  output logic           busy
`ifdef SHARED_REG_OWNER_EN
  ,
  output logic [IDW-1:0] owner
`endif
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [K-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] idx_q, idx_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   q_q, q_d;
  logic           valid_q, valid_d;
`ifdef SHARED_REG_OWNER_EN
  logic [IDW-1:0] owner_q, owner_d;
`endif

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [K-1:0]   win_onehot;
  logic [N-1:0]   slice [K];

  // Unpack the per-requester data words.
  for (genvar g = 0; g < K; g++) begin : g_slice
    assign slice[g] = data[g*N +: N];
  end

  // Round-robin search: first request at or above the pointer, else the lowest one
  // (which is the wrapped part of the search order).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < K; i++) begin
      if (!win_found && req[i] && (32'(i) >= 32'(ptr_q))) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < K; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end

  // One-hot decode of the winner index.
  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < K; i++) begin
      win_onehot[i] = (win_idx == IDW'(i));
    end
  end

  // Next-state logic; data is sampled at the end of GRANT, not at grant time.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    valid_d = valid_q;
`ifdef SHARED_REG_OWNER_EN
    owner_d = owner_q;
`endif
    case (state_q)
      StIdle: begin
        if (!hold && win_found) begin
          state_d = StGrant;
          gnt_d   = win_onehot;
          idx_d   = win_idx;
        end
      end
      StGrant: begin
        state_d = StIdle;
        q_d     = slice[idx_q];
        valid_d = 1'b1;
        ptr_d   = (idx_q == IDW'(K - 1)) ? '0 : idx_q + 1'b1;
`ifdef SHARED_REG_OWNER_EN
        owner_d = idx_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; async reset abandons any in-flight load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
`ifdef SHARED_REG_OWNER_EN
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
`ifdef SHARED_REG_OWNER_EN
      owner_q <= owner_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign Q       = q_q;
  assign q_valid = valid_q;
  assign busy    = (state_q == StGrant);
`ifdef SHARED_REG_OWNER_EN
  assign owner   = owner_q;
`endif

endmodule

// File: tb/tb_shared_register_load_arbiter.sv
// Self-checking bench for shared_register_load_arbiter: directed steps followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_shared_register_load_arbiter;

  localparam int N   = 4;
  localparam int K   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [K-1:0]   req;
  logic [K*N-1:0] data;
  logic           hold;
  logic [K-1:0]   gnt;
  logic [N-1:0]   Q;
  logic           q_valid;
  logic           busy;
`ifdef SHARED_REG_OWNER_EN
  logic [IDW-1:0] owner;
`endif

  shared_register_load_arbiter #(.N(N), .K(K), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .data    (data),
    .hold    (hold),
    .gnt     (gnt),
    .Q       (Q),
    .q_valid (q_valid),
    .busy    (busy)
`ifdef SHARED_REG_OWNER_EN
    ,
    .owner   (owner)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: pointer, pending winner (-1 when none), register contents.
  int         m_ptr;
  int         m_pend;
  logic [N-1:0] m_q;
  logic       m_valid;
  int         m_owner;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_pend  = -1;
    m_q     = '0;
    m_valid = 1'b0;
    m_owner = 0;
  endtask

  // Apply one clock edge to the model using the inputs the DUT sees at that edge.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (m_pend >= 0) begin
      m_q     = data[m_pend*N +: N];
      m_valid = 1'b1;
      m_owner = m_pend;
      m_ptr   = (m_pend + 1) % K;
      m_pend  = -1;
    end else if (!hold && req != '0) begin
      for (int j = 0; j < K; j++) begin
        int c;
        c = (m_ptr + j) % K;
        if (req[c]) begin
          m_pend = c;
          break;
        end
      end
    end
  endtask

  function automatic logic [K-1:0] exp_gnt();
    logic [K-1:0] g;
    g = '0;
    if (m_pend >= 0) g[m_pend] = 1'b1;
    return g;
  endfunction

  task automatic check_outputs(string tag);
    chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt()));
    chk({tag, " busy"}, 32'(busy), 32'(m_pend >= 0));
    chk({tag, " Q"}, 32'(Q), 32'(m_q));
    chk({tag, " q_valid"}, 32'(q_valid), 32'(m_valid));
`ifdef SHARED_REG_OWNER_EN
    chk({tag, " owner"}, 32'(owner), 32'(m_owner));
`endif
  endtask

  // One clock: advance model at the edge, compare 1 time unit later.
  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  int   order[$];
  int   gcyc[$];
  int   qseq[$];
  logic was_gnt;
  int   exp_order[5] = '{0, 1, 2, 3, 0};
  int   exp_qseq[5]  = '{1, 2, 3, 4, 1};

  initial begin
    reset_n = 1'b0;
    req     = '0;
    data    = '0;
    hold    = 1'b0;
    model_reset();

    // Reset, then idle with no requests.
    repeat (3) cycle("reset");
    reset_n = 1'b1;
    repeat (10) cycle("idle");

    // Single requester 2 with data 0xA.
    req  = 4'b0100;
    data = 16'h0A00;
    cycle("single_gnt");
    chk("single gnt const", 32'(gnt), 32'h4);
    req = '0;
    cycle("single_load");
    chk("single Q const", 32'(Q), 32'hA);
    chk("single valid const", 32'(q_valid), 32'h1);
`ifdef SHARED_REG_OWNER_EN
    chk("single owner const", 32'(owner), 32'h2);
`endif

    // Round-robin fairness from a fresh pointer.
    reset_n = 1'b0;
    cycle("rr_reset");
    reset_n = 1'b1;
    req     = 4'b1111;
    data    = 16'h4321;
    was_gnt = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle("rr");
      if (was_gnt) qseq.push_back(int'(Q));
      for (int i = 0; i < K; i++) begin
        if (gnt[i]) begin
          order.push_back(i);
          gcyc.push_back(c);
        end
      end
      was_gnt = |gnt;
    end
    req = '0;
    chk("rr grant count", 32'(order.size()), 32'd5);
    chk("rr load count", 32'(qseq.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk("rr order", 32'(order[i]), 32'(exp_order[i]));
      if (i < qseq.size()) chk("rr Q seq", 32'(qseq[i]), 32'(exp_qseq[i]));
      if (i > 0 && i < gcyc.size()) chk("rr spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
    end

    // Hold blocks arbitration in IDLE.
    cycle("pre_hold");
    req  = 4'b0010;
    hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle("hold");
      chk("hold gnt const", 32'(gnt), 32'h0);
      chk("hold Q const", 32'(Q), 32'h1);
    end
    hold = 1'b0;
    cycle("hold_release");
    chk("hold release gnt", 32'(gnt), 32'h2);
    req = '0;
    cycle("hold_load");

    // Wrap and skip.
    req = 4'b1000;
    cycle("wrap_g3");
    chk("wrap gnt3", 32'(gnt), 32'h8);
    req = 4'b1001;
    cycle("wrap_l3");
    cycle("wrap_g0");
    chk("wrap gnt0", 32'(gnt), 32'h1);
    cycle("wrap_l0");
    cycle("wrap_g3b");
    chk("wrap gnt3 again", 32'(gnt), 32'h8);
    req = '0;
    cycle("wrap_l3b");

    // Randomized traffic, including hold during GRANT and protocol violations.
    for (int c = 0; c < 300; c++) begin
      req  = K'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      hold = ($urandom_range(0, 3) == 0);
      data = K*N'($urandom);
      cycle("rand");
    end

    // Async reset in the middle of a GRANT cycle.
    req  = '0;
    hold = 1'b0;
    cycle("drain");
    cycle("drain");
    req  = 4'b0010;
    data = 16'h00C0;
    cycle("pre_rst_g");
    req = '0;
    cycle("pre_rst_l");
    chk("pre rst Q const", 32'(Q), 32'hC);
    req  = 4'b0100;
    data = 16'h0500;
    cycle("rst_g");
    chk("rst gnt before", 32'(gnt), 32'h4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    chk("async rst Q const", 32'(Q), 32'h0);
    chk("async rst gnt const", 32'(gnt), 32'h0);
    cycle("rst_held");
    req     = '0;
    reset_n = 1'b1;
    cycle("post_rst");
    chk("post rst Q const", 32'(Q), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
